// File: rtl/heartbeat_decoder.sv
// Manchester heartbeat receiver: recovers bits from edge intervals, then finds byte
// alignment and polarity from a rolling +1 (or -1 when inverted) counter sequence.
module heartbeat_decoder #(
  parameter int HALF_BIT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       locked,
  output logic       inverted,
  output logic [7:0] err_count
);

  localparam logic [7:0] S_TH        = 8'(HALF_BIT_CYCLES / 32'sd2);
  localparam logic [7:0] L_TH        = 8'((32'sd3 * HALF_BIT_CYCLES) / 32'sd2);
  localparam logic [7:0] X_TH        = 8'((32'sd5 * HALF_BIT_CYCLES) / 32'sd2);
  localparam logic [7:0] TMO         = X_TH + 8'd1;
  localparam logic [4:0] FULL_WINDOW = 5'd24;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    MID   = 2'd1,
    BOUND = 2'd2
  } bit_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic            sync1_r, sync2_r, sync3_r;
  logic            edge_s;
  logic [7:0]      ival_r;
  logic            armed_r;
  logic            glitch_s, long_s, short_s, timeout_s;
  logic            emit_s, bound_err_s, dec_err_s;
  bit_state_e      state_r, state_s;

  logic [23:0]     sr_r, sr_s, sr_shift_s;
  logic [4:0]      nbits_r, nbits_s, nbits_inc_s;
  logic [2:0]      phase_r, phase_s;
  logic [7:0]      byte_r, byte_s;
  logic [7:0]      err_r, err_s;
  logic            valid_r, valid_s;
  logic            locked_r, locked_s;
  logic            inv_r, inv_s;
  logic [7:0]      a_s, b_s, c_s, v_s;
  logic            up_s, dn_s, seq_ok_s, window_full_s;

  assign edge_s    = sync2_r ^ sync3_r;
  assign timeout_s = armed_r & ~edge_s & (ival_r == X_TH);
  assign dec_err_s = glitch_s | timeout_s | bound_err_s;

  // Synchronizer, edge history and interval counter; armed_r gates classification
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      ival_r  <= 8'd0;
      armed_r <= 1'b0;
    end else begin
      sync1_r <= signal_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      if (edge_s) begin
        ival_r <= 8'd1;
      end else if (ival_r != TMO) begin
        ival_r <= ival_r + 8'd1;
      end else begin
        ival_r <= ival_r;
      end
      if (dec_err_s) begin
        armed_r <= 1'b0;
      end else if (edge_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // Classify an armed edge by the interval that preceded it
  always_comb begin
    glitch_s = 1'b0;
    long_s   = 1'b0;
    short_s  = 1'b0;
    if (edge_s && armed_r) begin
      if (ival_r < S_TH) begin
        glitch_s = 1'b1;
      end else if (ival_r >= L_TH) begin
        long_s = 1'b1;
      end else begin
        short_s = 1'b1;
      end
    end else begin
      glitch_s = 1'b0;
    end
  end

  // Bit FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_s;
    end
  end

  // Bit FSM next state
  always_comb begin
    state_s = state_r;
    if (dec_err_s) begin
      state_s = HUNT;
    end else begin
      case (state_r)
        HUNT:    state_s = long_s  ? MID   : HUNT;
        MID:     state_s = short_s ? BOUND : MID;
        BOUND:   state_s = short_s ? MID   : BOUND;
        default: state_s = HUNT;
      endcase
    end
  end

  // Bit FSM outputs: mid-bit edges emit, a long interval from a boundary is illegal
  always_comb begin
    emit_s      = 1'b0;
    bound_err_s = 1'b0;
    case (state_r)
      HUNT:    emit_s = long_s;
      MID:     emit_s = long_s;
      BOUND: begin
        emit_s      = short_s;
        bound_err_s = long_s;
      end
      default: emit_s = 1'b0;
    endcase
  end

  assign sr_shift_s    = {sr_r[22:0], sync2_r};
  assign a_s           = sr_shift_s[23:16];
  assign b_s           = sr_shift_s[15:8];
  assign c_s           = sr_shift_s[7:0];
  assign up_s          = (b_s == a_s + 8'd1) && (c_s == b_s + 8'd1);
  assign dn_s          = (b_s == a_s - 8'd1) && (c_s == b_s - 8'd1);
  assign v_s           = sr_shift_s[7:0] ^ {8{inv_r}};
  assign seq_ok_s      = (v_s == byte_r + 8'd1);
  assign nbits_inc_s   = (nbits_r == FULL_WINDOW) ? nbits_r : nbits_r + 5'd1;
  assign window_full_s = (nbits_inc_s == FULL_WINDOW);

  // Byte assembly: alignment search while unlocked, sequence tracking while locked
  always_comb begin
    sr_s     = sr_r;
    nbits_s  = nbits_r;
    phase_s  = phase_r;
    byte_s   = byte_r;
    err_s    = err_r;
    valid_s  = 1'b0;
    locked_s = locked_r;
    inv_s    = inv_r;
    if (dec_err_s) begin
      nbits_s  = 5'd0;
      locked_s = 1'b0;
      err_s    = sat_inc8(err_r);
    end else if (emit_s) begin
      sr_s = sr_shift_s;
      if (locked_r) begin
        phase_s = phase_r + 3'd1;
        if (phase_r == 3'd7) begin
          if (seq_ok_s) begin
            byte_s  = v_s;
            valid_s = 1'b1;
          end else begin
            locked_s = 1'b0;
            nbits_s  = 5'd0;
            err_s    = sat_inc8(err_r);
          end
        end else begin
          valid_s = 1'b0;
        end
      end else begin
        nbits_s = nbits_inc_s;
        if (window_full_s && up_s) begin
          locked_s = 1'b1;
          inv_s    = 1'b0;
          byte_s   = c_s;
          valid_s  = 1'b1;
          phase_s  = 3'd0;
        end else if (window_full_s && dn_s) begin
          locked_s = 1'b1;
          inv_s    = 1'b1;
          byte_s   = ~c_s;
          valid_s  = 1'b1;
          phase_s  = 3'd0;
        end else begin
          valid_s = 1'b0;
        end
      end
    end else begin
      valid_s = 1'b0;
    end
  end

  // Byte assembly and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_r     <= 24'd0;
      nbits_r  <= 5'd0;
      phase_r  <= 3'd0;
      byte_r   <= 8'd0;
      err_r    <= 8'd0;
      valid_r  <= 1'b0;
      locked_r <= 1'b0;
      inv_r    <= 1'b0;
    end else begin
      sr_r     <= sr_s;
      nbits_r  <= nbits_s;
      phase_r  <= phase_s;
      byte_r   <= byte_s;
      err_r    <= err_s;
      valid_r  <= valid_s;
      locked_r <= locked_s;
      inv_r    <= inv_s;
    end
  end

  assign byte_out   = byte_r;
  assign byte_valid = valid_r;
  assign locked     = locked_r;
  assign inverted   = inv_r;
  assign err_count  = err_r;

endmodule
